// File: rtl/mips32_mem_arbiter.sv
// mips32_mem_arbiter: shares one synchronous 1024x32 RAM between data, fetch and loader ports.
module mips32_mem_arbiter #(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 8
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  input  logic              l_req,
  input  logic              l_we,
  input  logic [ADDR_W-1:0] l_addr,
  input  logic [DATA_W-1:0] l_wdata,
  output logic              l_gnt,
  output logic              l_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0] MW = WW'(MAX_WAIT);
  typedef struct packed {
    logic       v;
    logic       rd;
    logic [1:0] port;
  } tag_t;
  logic [WW-1:0] i_wait, l_wait;
  logic          i_aged, l_aged, any_gnt, sel_we, ret;
  tag_t          tag1, tag2, tag_n;
  always_comb begin
    i_aged  = i_req && i_wait == MW;
    l_aged  = l_req && l_wait == MW;
    i_gnt   = !rst && i_req && (i_aged || (!l_aged && !d_req));
    l_gnt   = !rst && l_req && !i_aged && (l_aged || (!d_req && !i_req));
    d_gnt   = !rst && d_req && !i_aged && !l_aged;
    any_gnt = d_gnt || i_gnt || l_gnt;
    sel_we  = d_gnt ? d_we : l_gnt ? l_we : 1'b0;
    tag_n   = '{v: any_gnt, rd: !sel_we, port: d_gnt ? 2'd0 : i_gnt ? 2'd1 : 2'd2};
    // rst also masks responses so in-flight reads never surface
    ret      = !rst && tag2.v && tag2.rd;
    d_rvalid = ret && tag2.port == 2'd0;
    i_rvalid = ret && tag2.port == 2'd1;
    l_rvalid = ret && tag2.port == 2'd2;
    rdata    = ret ? mem_rdata : '0;
  end
  always_ff @(posedge clk1) begin
    if (rst) begin
      i_wait    <= '0;
      l_wait    <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      tag1      <= '0;
      tag2      <= '0;
    end else begin
      i_wait <= (!i_req || i_gnt) ? '0 : (i_wait == MW ? MW : i_wait + 1'b1);
      l_wait <= (!l_req || l_gnt) ? '0 : (l_wait == MW ? MW : l_wait + 1'b1);
      mem_en <= any_gnt;
      if (any_gnt) begin
        mem_we   <= sel_we;
        mem_addr <= d_gnt ? d_addr : i_gnt ? i_addr : l_addr;
      end
      if (d_gnt || l_gnt) mem_wdata <= d_gnt ? d_wdata : l_wdata;
      tag1 <= tag_n;
      tag2 <= tag1;
    end
  end
endmodule

// File: tb/tb_mips32_mem_arbiter.sv
// tb_mips32_mem_arbiter: directed scenarios plus randomized traffic against a grant-level reference model.
module tb_mips32_mem_arbiter;
  localparam int MW = 8;
  logic        clk1 = 1'b0;
  logic        rst;
  logic        d_req, d_we, d_gnt, d_rvalid;
  logic [9:0]  d_addr;
  logic [31:0] d_wdata;
  logic        i_req, i_gnt, i_rvalid;
  logic [9:0]  i_addr;
  logic        l_req, l_we, l_gnt, l_rvalid;
  logic [9:0]  l_addr;
  logic [31:0] l_wdata;
  logic [31:0] rdata;
  logic        mem_en, mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic [31:0] ram [0:1023];
  int checks = 0, errors = 0;

  typedef struct {
    bit          v;
    bit          rd;
    int          port;
    logic [9:0]  addr;
    logic [31:0] data;
  } ent_t;

  always #5 clk1 = ~clk1;

  always @(posedge clk1)
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else mem_rdata <= ram[mem_addr];
    end

  mips32_mem_arbiter dut (
    .clk1(clk1), .rst(rst),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rvalid(d_rvalid),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata), .l_gnt(l_gnt), .l_rvalid(l_rvalid),
    .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  task automatic step();
    @(posedge clk1);
    #1;
  endtask

  task automatic idle();
    d_req = 0; i_req = 0; l_req = 0; d_we = 0; l_we = 0;
  endtask

  task automatic test_reset();
    d_req = 1; i_req = 1; l_req = 1;
    #1;
    checks++;
    if ({d_gnt, i_gnt, l_gnt} !== 3'b000) begin
      errors++; $display("FAIL reset_gnt: got %b exp 000", {d_gnt, i_gnt, l_gnt});
    end
    step();
    checks++;
    if ({mem_en, mem_we, d_rvalid, i_rvalid, l_rvalid} !== 5'b0 || mem_addr !== 10'd0 || mem_wdata !== 32'd0 || rdata !== 32'd0) begin
      errors++; $display("FAIL reset_state: got en=%b we=%b rv=%b%b%b addr=%h wdata=%h rdata=%h exp all zero",
                         mem_en, mem_we, d_rvalid, i_rvalid, l_rvalid, mem_addr, mem_wdata, rdata);
    end
    rst = 0; idle();
    repeat (2) step();
  endtask

  task automatic test_fetch_read();
    l_req = 1; l_we = 1; l_addr = 10'd5; l_wdata = 32'hDEADBEEF;
    #1;
    checks++;
    if ({d_gnt, i_gnt, l_gnt} !== 3'b001) begin
      errors++; $display("FAIL load_gnt: got %b exp 001", {d_gnt, i_gnt, l_gnt});
    end
    step();
    idle(); i_req = 1; i_addr = 10'd5;
    checks++;
    if ({mem_en, mem_we} !== 2'b11 || mem_addr !== 10'd5 || mem_wdata !== 32'hDEADBEEF) begin
      errors++; $display("FAIL load_cmd: got en=%b we=%b addr=%h wdata=%h exp 1 1 005 deadbeef", mem_en, mem_we, mem_addr, mem_wdata);
    end
    #1;
    checks++;
    if ({d_gnt, i_gnt, l_gnt} !== 3'b010) begin
      errors++; $display("FAIL fetch_gnt: got %b exp 010", {d_gnt, i_gnt, l_gnt});
    end
    step();
    i_req = 0;
    checks++;
    if ({mem_en, mem_we} !== 2'b10 || mem_addr !== 10'd5 || {d_rvalid, i_rvalid, l_rvalid} !== 3'b000) begin
      errors++; $display("FAIL fetch_cmd: got en=%b we=%b addr=%h exp 1 0 005", mem_en, mem_we, mem_addr);
    end
    step();
    checks++;
    if ({d_rvalid, i_rvalid, l_rvalid} !== 3'b010 || rdata !== 32'hDEADBEEF) begin
      errors++; $display("FAIL fetch_rdata: got rv=%b rdata=%h exp 010 deadbeef", {d_rvalid, i_rvalid, l_rvalid}, rdata);
    end
    step();
    checks++;
    if ({d_rvalid, i_rvalid, l_rvalid, mem_en} !== 4'b0000) begin
      errors++; $display("FAIL fetch_idle: got rv=%b en=%b exp 000 0", {d_rvalid, i_rvalid, l_rvalid}, mem_en);
    end
  endtask

  task automatic test_contention();
    l_req = 1; l_we = 1; l_addr = 10'd3; l_wdata = 32'hAAAA0003;
    step();
    l_addr = 10'd7; l_wdata = 32'hBBBB0007;
    step();
    idle();
    d_req = 1; d_we = 0; d_addr = 10'd3; i_req = 1; i_addr = 10'd7;
    #1;
    checks++;
    if ({d_gnt, i_gnt, l_gnt} !== 3'b100) begin
      errors++; $display("FAIL cont_first: got %b exp 100", {d_gnt, i_gnt, l_gnt});
    end
    step();
    d_req = 0;
    #1;
    checks++;
    if ({d_gnt, i_gnt, l_gnt} !== 3'b010) begin
      errors++; $display("FAIL cont_second: got %b exp 010", {d_gnt, i_gnt, l_gnt});
    end
    step();
    i_req = 0;
    checks++;
    if ({d_rvalid, i_rvalid, l_rvalid} !== 3'b100 || rdata !== 32'hAAAA0003) begin
      errors++; $display("FAIL cont_d_rvalid: got rv=%b rdata=%h exp 100 aaaa0003", {d_rvalid, i_rvalid, l_rvalid}, rdata);
    end
    step();
    checks++;
    if ({d_rvalid, i_rvalid, l_rvalid} !== 3'b010 || rdata !== 32'hBBBB0007) begin
      errors++; $display("FAIL cont_i_rvalid: got rv=%b rdata=%h exp 010 bbbb0007", {d_rvalid, i_rvalid, l_rvalid}, rdata);
    end
    repeat (2) step();
  endtask

  task automatic test_starvation();
    bit found = 0, d_ok = 1;
    int n = 0;
    d_req = 1; d_we = 0; d_addr = 10'd0; l_req = 1; l_we = 0; l_addr = 10'd1;
    for (int k = 0; k < 20 && !found; k++) begin
      #1;
      if (l_gnt) found = 1;
      else begin
        if (!d_gnt) d_ok = 0;
        n++;
        step();
      end
    end
    checks++;
    if (!found || n != MW || !d_ok) begin
      errors++; $display("FAIL starve_age: got found=%0d refusals=%0d d_ok=%0d exp 1 %0d 1", found, n, d_ok, MW);
    end
    step();
    l_req = 0;
    #1;
    checks++;
    if ({d_gnt, i_gnt, l_gnt} !== 3'b100) begin
      errors++; $display("FAIL starve_resume: got %b exp 100", {d_gnt, i_gnt, l_gnt});
    end
    idle();
    repeat (3) step();
  endtask

  task automatic test_write_read();
    bit l_seen = 0;
    l_req = 1; l_we = 1; l_addr = 10'd10; l_wdata = 32'h1234;
    #1;
    checks++;
    if (l_gnt !== 1'b1) begin
      errors++; $display("FAIL wr_gnt: got %b exp 1", l_gnt);
    end
    step();
    idle(); d_req = 1; d_we = 0; d_addr = 10'd10;
    #1;
    checks++;
    if (d_gnt !== 1'b1) begin
      errors++; $display("FAIL rd_gnt: got %b exp 1", d_gnt);
    end
    step();
    d_req = 0;
    l_seen |= l_rvalid;
    step();
    l_seen |= l_rvalid;
    checks++;
    if (d_rvalid !== 1'b1 || rdata !== 32'h1234) begin
      errors++; $display("FAIL wr_rd_data: got rv=%b rdata=%h exp 1 00001234", d_rvalid, rdata);
    end
    step();
    l_seen |= l_rvalid;
    checks++;
    if (l_seen) begin
      errors++; $display("FAIL wr_no_rvalid: got l_rvalid seen=1 exp 0");
    end
  endtask

  task automatic test_both_aged();
    logic [2:0] g, e;
    d_req = 1; d_we = 0; d_addr = 10'd0; i_req = 1; i_addr = 10'd2; l_req = 1; l_we = 0; l_addr = 10'd3;
    for (int k = 0; k <= MW + 2; k++) begin
      #1;
      g = {d_gnt, i_gnt, l_gnt};
      e = k < MW ? 3'b100 : k == MW ? 3'b010 : k == MW + 1 ? 3'b001 : 3'b100;
      checks++;
      if (g !== e) begin
        errors++; $display("FAIL aged_cycle%0d: got %b exp %b", k, g, e);
      end
      step();
      if (g[1]) i_req = 0;
      if (g[0]) l_req = 0;
    end
    idle();
    repeat (3) step();
  endtask

  task automatic test_reset_inflight();
    d_req = 1; d_we = 0; d_addr = 10'd10; l_req = 1; l_we = 0; l_addr = 10'd5;
    step();
    d_req = 0; i_req = 1; i_addr = 10'd7;
    #1;
    checks++;
    if ({d_gnt, i_gnt, l_gnt} !== 3'b010) begin
      errors++; $display("FAIL rstfl_gnt: got %b exp 010", {d_gnt, i_gnt, l_gnt});
    end
    step();
    i_req = 0; rst = 1;
    #1;
    checks++;
    if ({d_rvalid, i_rvalid, l_rvalid} !== 3'b000 || rdata !== 32'd0) begin
      errors++; $display("FAIL rstfl_mask: got rv=%b rdata=%h exp 000 0", {d_rvalid, i_rvalid, l_rvalid}, rdata);
    end
    step();
    checks++;
    if ({mem_en, d_rvalid, i_rvalid, l_rvalid} !== 4'b0 || dut.i_wait !== '0 || dut.l_wait !== '0) begin
      errors++; $display("FAIL rstfl_state: got en=%b rv=%b i_wait=%0d l_wait=%0d exp 0 000 0 0",
                         mem_en, {d_rvalid, i_rvalid, l_rvalid}, dut.i_wait, dut.l_wait);
    end
    rst = 0; idle();
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if ({d_rvalid, i_rvalid, l_rvalid} !== 3'b000) begin
        errors++; $display("FAIL rstfl_after%0d: got rv=%b exp 000", k, {d_rvalid, i_rvalid, l_rvalid});
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] gold [0:15];
    ent_t p1, p2, cur;
    int ia = 0, la = 0, w = 3;
    logic [2:0] erv;
    for (int a = 0; a < 16; a++) begin
      l_req = 1; l_we = 1; l_addr = 10'(a); l_wdata = $urandom;
      gold[a] = l_wdata;
      step();
    end
    idle();
    repeat (3) step();
    p1 = '{v: 0, rd: 0, port: 0, addr: '0, data: '0};
    p2 = p1;
    for (int c = 0; c < 3000; c++) begin
      erv = (p2.v && p2.rd) ? 3'(1 << p2.port) : 3'b000;
      checks++;
      if ({l_rvalid, i_rvalid, d_rvalid} !== erv || (erv != 0 && rdata !== p2.data)) begin
        errors++; $display("FAIL rand_resp c%0d: got rv(lid)=%b rdata=%h exp %b %h", c, {l_rvalid, i_rvalid, d_rvalid}, rdata, erv, p2.data);
      end
      checks++;
      if (mem_en !== p1.v || (p1.v && (mem_addr !== p1.addr || mem_we !== !p1.rd))) begin
        errors++; $display("FAIL rand_cmd c%0d: got en=%b addr=%h we=%b exp %b %h %b", c, mem_en, mem_addr, mem_we, p1.v, p1.addr, !p1.rd);
      end
      if (w == 0 || !d_req) begin
        d_req = $urandom_range(0, 9) < 6; d_we = $urandom_range(0, 1) == 1;
        d_addr = 10'($urandom_range(0, 15)); d_wdata = $urandom;
      end
      if (w == 1 || !i_req) begin
        i_req = $urandom_range(0, 9) < 5; i_addr = 10'($urandom_range(0, 15));
      end
      if (w == 2 || !l_req) begin
        l_req = $urandom_range(0, 9) < 3; l_we = $urandom_range(0, 1) == 1;
        l_addr = 10'($urandom_range(0, 15)); l_wdata = $urandom;
      end
      #1;
      w = (i_req && ia >= MW) ? 1 : (l_req && la >= MW) ? 2 : d_req ? 0 : i_req ? 1 : l_req ? 2 : 3;
      checks++;
      if ({d_gnt, i_gnt, l_gnt} !== {w == 0, w == 1, w == 2}) begin
        errors++; $display("FAIL rand_gnt c%0d: got %b exp port %0d", c, {d_gnt, i_gnt, l_gnt}, w);
      end
      cur.v = w != 3;
      cur.port = w;
      cur.addr = w == 0 ? d_addr : w == 1 ? i_addr : l_addr;
      cur.rd = w == 0 ? !d_we : w == 2 ? !l_we : 1'b1;
      cur.data = gold[cur.addr[3:0]];
      if (cur.v && !cur.rd) gold[cur.addr[3:0]] = w == 0 ? d_wdata : l_wdata;
      ia = (!i_req || w == 1) ? 0 : (ia + 1 > MW ? MW : ia + 1);
      la = (!l_req || w == 2) ? 0 : (la + 1 > MW ? MW : la + 1);
      p2 = p1;
      p1 = cur;
      step();
    end
    idle();
    repeat (3) step();
  endtask

  initial begin
    rst = 1; idle();
    d_addr = '0; d_wdata = '0; i_addr = '0; l_addr = '0; l_wdata = '0;
    repeat (2) step();
    test_reset();
    test_fetch_read();
    test_contention();
    test_starvation();
    test_write_read();
    test_both_aged();
    test_reset_inflight();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
